// File: rtl/video_stream_gen.sv
// video_stream_gen
//   AXI4-Stream video test-pattern source. It stands in for the camera
//   pipeline output upstream of the gamma/debug stage. It emits complete
//   frames with video framing: tuser marks the first pixel of a frame and
//   tlast marks the last pixel of each line. Idle gaps follow every line and
//   every frame.
//
//   Optional feature macro: VSG_BURST_EN
//     defined   -> beats in a line are grouped into bursts of BURST_ON
//                  transfers. Each burst is followed by BURST_OFF idle cycles.
//     undefined -> tvalid is continuous for the whole line.
//
// Ports
//   clk                  in   clock, rising edge
//   rstn                 in   asynchronous active-low reset
//   enable               in   run request; sampled in IDLE and at frame end
//   pattern[1:0]         in   0 ramp, 1 colour bars, 2 checker, 3 flat;
//                             latched at frame start
//   m_axis_video_tready  in   downstream ready
//   m_axis_video_tdata   out  {2'b00, R[9:0], G[9:0], B[9:0]}
//   m_axis_video_tvalid  out  beat valid
//   m_axis_video_tuser   out  start of frame (x==0, y==0)
//   m_axis_video_tlast   out  end of line (x==H_ACTIVE-1)
//   frame_count[15:0]    out  completed frames, wraps
//   busy                 out  high whenever the FSM is not in IDLE
module video_stream_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int LINE_GAP  = 1750,
  parameter int FRAME_GAP = 500000,
  parameter int BURST_ON  = 4,
  parameter int BURST_OFF = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic        m_axis_video_tready,
  output logic [31:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_LEN = H_ACTIVE / 8;
  localparam int BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
  localparam int MAX_GAP = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
  localparam int GW      = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;

  localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_LEN - 1);
  localparam logic [GW-1:0] LGAP_LAST = GW'(LINE_GAP - 1);
  localparam logic [GW-1:0] FGAP_LAST = GW'(FRAME_GAP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LINE = 2'd1;
  localparam logic [1:0] S_LGAP = 2'd2;
  localparam logic [1:0] S_FGAP = 2'd3;

  // Elaboration-time parameter range checks.
  if (H_ACTIVE < 8 || (H_ACTIVE % 8) != 0 || V_ACTIVE < 1 ||
      LINE_GAP < 1 || FRAME_GAP < 1 || BURST_ON < 1 || BURST_OFF < 1) begin : g_param_chk
    $error("video_stream_gen: parameter out of range");
  end

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    ramp_q, ramp_d;
  logic [2:0]    bar_q, bar_d;
  logic [BW-1:0] bar_px_q, bar_px_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic line_valid;
  logic xfer;
  logic last_beat;

  assign xfer      = line_valid & m_axis_video_tready;
  assign last_beat = (x_q == X_LAST);

`ifdef VSG_BURST_EN
  localparam int BCW = (BURST_ON > 1) ? $clog2(BURST_ON) : 1;
  localparam int OCW = (BURST_OFF > 1) ? $clog2(BURST_OFF) : 1;
  localparam logic [BCW-1:0] ON_LAST  = BCW'(BURST_ON - 1);
  localparam logic [OCW-1:0] OFF_LAST = OCW'(BURST_OFF - 1);

  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic [OCW-1:0] off_cnt_q, off_cnt_d;
  logic           off_q, off_d;

  assign line_valid = (state_q == S_LINE) && !off_q;

  // The burst phase only lives inside LINE. Leaving LINE clears it, so every
  // line starts with a full burst. The off phase has no beats, so it counts
  // cycles rather than transfers.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    off_cnt_d   = off_cnt_q;
    off_d       = off_q;
    if (state_q != S_LINE) begin
      burst_cnt_d = '0;
      off_cnt_d   = '0;
      off_d       = 1'b0;
    end else if (off_q) begin
      if (off_cnt_q == OFF_LAST) begin
        off_cnt_d = '0;
        off_d     = 1'b0;
      end else begin
        off_cnt_d = off_cnt_q + OCW'(1);
      end
    end else if (xfer) begin
      if (last_beat) begin
        burst_cnt_d = '0;
      end else if (burst_cnt_q == ON_LAST) begin
        burst_cnt_d = '0;
        off_cnt_d   = '0;
        off_d       = 1'b1;
      end else begin
        burst_cnt_d = burst_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      burst_cnt_q <= '0;
      off_cnt_q   <= '0;
      off_q       <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      off_cnt_q   <= off_cnt_d;
      off_q       <= off_d;
    end
  end
`else
  assign line_valid = (state_q == S_LINE);
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    ramp_d      = ramp_q;
    bar_d       = bar_q;
    bar_px_d    = bar_px_q;
    gap_d       = gap_q;
    pat_d       = pat_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_LINE;
          pat_d    = pattern;
          x_d      = '0;
          y_d      = '0;
          ramp_d   = '0;
          bar_d    = '0;
          bar_px_d = '0;
        end
      end
      S_LINE: begin
        if (xfer) begin
          ramp_d = ramp_q + 4'd1;
          if (last_beat) begin
            x_d      = '0;
            bar_d    = '0;
            bar_px_d = '0;
            gap_d    = '0;
            if (y_q == Y_LAST) begin
              state_d     = S_FGAP;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              state_d = S_LGAP;
            end
          end else begin
            x_d = x_q + XW'(1);
            // Bar index tracks x/(H_ACTIVE/8) incrementally.
            if (bar_px_q == BAR_LAST) begin
              bar_px_d = '0;
              bar_d    = bar_q + 3'd1;
            end else begin
              bar_px_d = bar_px_q + BW'(1);
            end
          end
        end
      end
      S_LGAP: begin
        if (gap_q == LGAP_LAST) begin
          gap_d   = '0;
          x_d     = '0;
          y_d     = y_q + YW'(1);
          state_d = S_LINE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        if (gap_q == FGAP_LAST) begin
          gap_d = '0;
          if (enable) begin
            state_d  = S_LINE;
            pat_d    = pattern;
            x_d      = '0;
            y_d      = '0;
            ramp_d   = '0;
            bar_d    = '0;
            bar_px_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      ramp_q      <= '0;
      bar_q       <= '0;
      bar_px_q    <= '0;
      gap_q       <= '0;
      pat_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ramp_q      <= ramp_d;
      bar_q       <= bar_d;
      bar_px_q    <= bar_px_d;
      gap_q       <= gap_d;
      pat_q       <= pat_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Bit 4 of x/y for the checker. A dimension too narrow to have a bit 4
  // reads it as 0.
  logic x_b4, y_b4;
  if (XW > 4) begin : g_xb4
    assign x_b4 = x_q[4];
  end else begin : g_xb4_zero
    assign x_b4 = 1'b0;
  end
  if (YW > 4) begin : g_yb4
    assign y_b4 = y_q[4];
  end else begin : g_yb4_zero
    assign y_b4 = 1'b0;
  end

  // Pixel data depends only on registered state, so it holds steady while
  // a beat is stalled.
  logic [9:0] r_c, g_c, b_c;
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    case (pat_q)
      2'd0: begin
        r_c = {ramp_q, 6'b0};
        g_c = r_c;
        b_c = r_c;
      end
      2'd1: begin
        r_c = bar_q[2] ? 10'h3FF : 10'h000;
        g_c = bar_q[1] ? 10'h3FF : 10'h000;
        b_c = bar_q[0] ? 10'h3FF : 10'h000;
      end
      2'd2: begin
        r_c = (x_b4 ^ y_b4) ? 10'h3FF : 10'h000;
        g_c = r_c;
        b_c = r_c;
      end
      default: begin
        r_c = {frame_cnt_q[3:0], 6'b0};
        g_c = r_c;
        b_c = r_c;
      end
    endcase
  end

  assign m_axis_video_tvalid = line_valid;
  assign m_axis_video_tdata  = line_valid ? {2'b00, r_c, g_c, b_c} : 32'd0;
  assign m_axis_video_tuser  = line_valid && (x_q == '0) && (y_q == '0);
  assign m_axis_video_tlast  = line_valid && last_beat;
  assign frame_count         = frame_cnt_q;
  assign busy                = (state_q != S_IDLE);

endmodule

// File: tb/tb_video_stream_gen.sv
`timescale 1ns/1ps
module tb_video_stream_gen;
  localparam int H    = 16;
  localparam int V    = 4;
  localparam int LG   = 5;
  localparam int FG   = 20;
  localparam int BON  = 4;
  localparam int BOFF = 3;
`ifdef VSG_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [1:0]  pattern;
  logic        tready;
  logic [31:0] tdata;
  logic        tvalid, tuser, tlast;
  logic [15:0] frame_count;
  logic        busy;

  always #5 clk = ~clk;

  video_stream_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .LINE_GAP(LG), .FRAME_GAP(FG),
    .BURST_ON(BON), .BURST_OFF(BOFF)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .enable              (enable),
    .pattern             (pattern),
    .m_axis_video_tready (tready),
    .m_axis_video_tdata  (tdata),
    .m_axis_video_tvalid (tvalid),
    .m_axis_video_tuser  (tuser),
    .m_axis_video_tlast  (tlast),
    .frame_count         (frame_count),
    .busy                (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [9:0] v4(input int v);
    logic [3:0] n;
    n = 4'(v % 16);
    return {n, 6'b0};
  endfunction

  // Pixel for beat number k of a frame (k counts transfers from 0).
  function automatic logic [31:0] expect_pixel(input int p, input int k, input int fc);
    int x, y, bar;
    logic [9:0] r, g, b;
    x = k % H;
    y = k / H;
    case (p)
      0: begin r = v4(k); g = r; b = r; end
      1: begin
        bar = x / (H / 8);
        r = ((bar & 4) != 0) ? 10'h3FF : 10'h000;
        g = ((bar & 2) != 0) ? 10'h3FF : 10'h000;
        b = ((bar & 1) != 0) ? 10'h3FF : 10'h000;
      end
      2: begin r = ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 10'h3FF : 10'h000; g = r; b = r; end
      default: begin r = v4(fc); g = r; b = r; end
    endcase
    return {2'b00, r, g, b};
  endfunction

  // What ended the last transfer: 0 mid-burst/line, 1 burst end, 2 line end, 3 frame end.
  int          k = 0;
  int          cur_pat = 0;
  int          fc_model = 0;
  int          low_run = FG;
  int          kind = 3;
  int          total_beats = 0;
  int          frames_done = 0;
  bit          must_rise = 0;
  logic        prev_tvalid = 0, prev_tready = 0, prev_tuser = 0, prev_tlast = 0, prev_enable = 0;
  logic [31:0] prev_tdata = 0;
  logic [1:0]  prev_pattern = 0;
  logic [31:0] frame_data [0:H*V-1];

  always @(negedge clk) begin
    if (!rstn) begin
      check("reset_ctrl", {12'd0, tvalid, tuser, tlast, busy, frame_count}, 32'd0);
      check("reset_tdata", tdata, 32'd0);
      k = 0; fc_model = 0; low_run = FG; kind = 3; must_rise = 0;
      prev_tvalid = 0; prev_tready = 0;
    end else begin
      check("frame_count", frame_count, fc_model);
      if (prev_tvalid && !prev_tready) begin
        check("stall_hold_valid", tvalid, 1);
        check("stall_hold_beat", {tdata[29:0], tuser, tlast}, {prev_tdata[29:0], prev_tuser, prev_tlast});
      end
      if (tvalid) begin
        if (!prev_tvalid) begin
          case (kind)
            0: check("mid_line_gap", low_run, 0);
            1: check("burst_off_len", low_run, BOFF);
            2: check("line_gap_len", low_run, LG);
            default: check("frame_start_ok", (low_run >= FG) && prev_enable, 1);
          endcase
          if (k == 0) cur_pat = prev_pattern;
        end
        check("busy_in_line", busy, 1);
        check("tdata", tdata, expect_pixel(cur_pat, k, fc_model));
        check("tuser", tuser, (k == 0));
        check("tlast", tlast, ((k % H) == H - 1));
        if (tready) begin
          frame_data[k] = tdata;
          total_beats++;
          low_run = 0;
          if (k == H * V - 1) begin
            kind = 3;
            k = 0;
            fc_model = (fc_model + 1) % 65536;
            frames_done++;
            $display("frame %0d complete: pattern %0d, total beats %0d, frame_count now %0d",
                     frames_done, cur_pat, total_beats, fc_model);
          end else begin
            if ((k % H) == H - 1) kind = 2;
            else if (BURST && (((k % H) + 1) % BON) == 0) kind = 1;
            else kind = 0;
            k++;
          end
        end
        must_rise = 0;
      end else begin
        low_run++;
        if (must_rise) check("frame_start_late", tvalid, 1);
        check("busy_in_gap", busy, (kind != 3) || (low_run <= FG));
        if (kind == 0 && low_run == 1) check("valid_drop_mid_line", low_run, 0);
        if (kind == 1 && low_run == BOFF + 1) check("burst_off_late", low_run, BOFF);
        if (kind == 2 && low_run == LG + 1) check("line_gap_late", low_run, LG);
        must_rise = (kind == 3) && (low_run >= FG) && enable;
      end
      prev_tvalid = tvalid; prev_tready = tready; prev_tdata = tdata;
      prev_tuser  = tuser;  prev_tlast  = tlast;
    end
    prev_enable  = enable;
    prev_pattern = pattern;
  end

  // ---------------- stimulus ----------------
  task automatic wait_frames_idle(input int frames, input int limit);
    int n = 0;
    while (!(frames_done >= frames && busy == 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_in_time", (n < limit), 1);
  endtask

  task automatic wait_beats(input int target, input int limit);
    int n = 0;
    while (total_beats < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("beat_wait_in_time", (n < limit), 1);
  endtask

  task automatic random_cycles(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      tready  = 1'($urandom_range(0, 1));
      pattern = 2'($urandom_range(0, 3));
      enable  = ($urandom_range(0, 7) != 0);
    end
  endtask

  initial begin
    int n;
    rstn = 1'b0; enable = 1'b0; tready = 1'b1; pattern = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lit_reset_tvalid", tvalid, 0);
    check("lit_reset_busy", busy, 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lit_idle_tvalid", tvalid, 0);

    // Ramp frame, tready held high; enable dropped during line 1.
    @(posedge clk); #1 enable = 1'b1; pattern = 2'd0;
    @(posedge clk);
    @(negedge clk);
    check("lit_first_tvalid", tvalid, 1);
    check("lit_first_tuser", tuser, 1);
    check("lit_first_tdata", tdata, 32'h0000_0000);
    @(negedge clk);
    check("lit_second_tdata", tdata, 32'h0401_0040);
    wait_beats(20, 200);
    @(posedge clk); #1 enable = 1'b0;
    wait_frames_idle(1, 1000);
    check("lit_frame1_beats", total_beats, 64);
    check("lit_frame1_count", frame_count, 16'd1);
    check("lit_ramp_x15", frame_data[15], 32'h3C0F_03C0);
    check("lit_ramp_line1_x0", frame_data[16], 32'h0000_0000);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("lit_no_beats_after_idle", total_beats, 64);
    check("lit_idle_busy", busy, 0);

    // Colour bars, one frame.
    @(posedge clk); #1 enable = 1'b1; pattern = 2'd1;
    @(posedge clk); #1 enable = 1'b0;
    wait_frames_idle(2, 1000);
    check("lit_frame2_beats", total_beats, 128);
    check("lit_bar_x0", frame_data[0], 32'h0000_0000);
    check("lit_bar_x2", frame_data[2], 32'h0000_03FF);
    check("lit_bar_x4", frame_data[4], 32'h000F_FC00);
    check("lit_bar_x15", frame_data[15], 32'h3FFF_FFFF);
    check("lit_frame2_count", frame_count, 16'd2);

    // Randomised backpressure, pattern and enable.
    random_cycles(2500);

    // Reset in the middle of a frame.
    enable = 1'b1;
    n = 0;
    while (tvalid !== 1'b1 && n < 1000) begin
      @(posedge clk); #1 tready = 1'($urandom_range(0, 1));
      n++;
    end
    check("midreset_frame_found", (n < 1000), 1);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("lit_midreset_tvalid", tvalid, 0);
    check("lit_midreset_count", frame_count, 16'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    random_cycles(1500);

    // Drain and stop.
    #1 enable = 1'b0; tready = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("final_idle_in_time", (n < 3000), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
